// File: rtl/bulls_cows_scorer_if.sv
// Handshake and operand/result bundle between the game controller and the
// Bulls & Cows scoring stage.
interface bulls_cows_scorer_if #(
    parameter int NUM_DIGITS = 4,
    parameter int CNT_W      = 3
);
    logic                    start;
    logic [4*NUM_DIGITS-1:0] secret;
    logic [4*NUM_DIGITS-1:0] guess;
    logic                    busy;
    logic                    done;
    logic                    valid_guess;
    logic [CNT_W-1:0]        bulls;
    logic [CNT_W-1:0]        cows;
    logic                    win;

    modport master (
        output start, secret, guess,
        input  busy, done, valid_guess, bulls, cows, win
    );

    modport slave (
        input  start, secret, guess,
        output busy, done, valid_guess, bulls, cows, win
    );
endinterface

// File: rtl/bulls_cows_scorer.sv
// Bulls & Cows scorer: latches a guess/secret pair, scores one guess digit per
// cycle, then publishes bulls/cows/valid/win together with a done pulse.
module bulls_cows_scorer #(
    parameter int NUM_DIGITS = 4,
    parameter int CNT_W      = 3
) (
    input  logic               clock,
    input  logic               reset,
    bulls_cows_scorer_if.slave bus
);
    localparam int CODE_W = 4 * NUM_DIGITS;
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] ALL_HIT  = CNT_W'(NUM_DIGITS);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COMPARE = 2'd1;
    localparam logic [1:0] S_REPORT  = 2'd2;

    logic [1:0]        r_state;
    logic [IDX_W-1:0]  r_index;
    logic [CODE_W-1:0] r_secret;
    logic [CODE_W-1:0] r_guess;
    logic [CNT_W-1:0]  r_work_bulls;
    logic [CNT_W-1:0]  r_work_cows;
    logic              r_invalid;

    logic              r_busy;
    logic              r_done;
    logic              r_valid;
    logic [CNT_W-1:0]  r_bulls;
    logic [CNT_W-1:0]  r_cows;
    logic              r_win;

    logic [3:0]        w_g_cur;
    logic [3:0]        w_s_cur;
    logic              w_is_bull;
    logic              w_in_other;
    logic              w_dup_later;
    logic              w_is_cow;
    logic              w_is_bad;
    logic [CNT_W-1:0]  w_bulls_nxt;
    logic [CNT_W-1:0]  w_cows_nxt;
    logic              w_invalid_nxt;
    logic [1:0]        w_state_nxt;

    // Classify the current guess digit against the latched secret and the
    // remaining (higher-index) guess digits.
    always_comb begin
        w_g_cur     = r_guess[{r_index, 2'b00} +: 4];
        w_s_cur     = r_secret[{r_index, 2'b00} +: 4];
        w_is_bull   = (w_g_cur == w_s_cur);
        w_in_other  = 1'b0;
        w_dup_later = 1'b0;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            w_in_other  = w_in_other |
                          ((IDX_W'(j) != r_index) && (r_secret[4*j +: 4] == w_g_cur));
            w_dup_later = w_dup_later |
                          ((IDX_W'(j) > r_index) && (r_guess[4*j +: 4] == w_g_cur));
        end
        w_is_cow = !w_is_bull && w_in_other;
        w_is_bad = (w_g_cur > 4'd9) || w_dup_later;
    end

    // Working totals including the digit being scored this cycle, so the
    // final digit is folded in on the edge that enters REPORT.
    always_comb begin
        w_bulls_nxt   = r_work_bulls + CNT_W'(w_is_bull);
        w_cows_nxt    = r_work_cows + CNT_W'(w_is_cow);
        w_invalid_nxt = r_invalid | w_is_bad;
    end

    // Next-state selection for the IDLE -> COMPARE -> REPORT sequence.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = S_COMPARE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_COMPARE: begin
                if (r_index == LAST_IDX) begin
                    w_state_nxt = S_REPORT;
                end else begin
                    w_state_nxt = S_COMPARE;
                end
            end
            S_REPORT: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // State, operand latch and working counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_index      <= {IDX_W{1'b0}};
            r_secret     <= {CODE_W{1'b0}};
            r_guess      <= {CODE_W{1'b0}};
            r_work_bulls <= {CNT_W{1'b0}};
            r_work_cows  <= {CNT_W{1'b0}};
            r_invalid    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_secret     <= bus.secret;
                        r_guess      <= bus.guess;
                        r_work_bulls <= {CNT_W{1'b0}};
                        r_work_cows  <= {CNT_W{1'b0}};
                        r_invalid    <= 1'b0;
                        r_index      <= {IDX_W{1'b0}};
                    end
                end
                S_COMPARE: begin
                    r_work_bulls <= w_bulls_nxt;
                    r_work_cows  <= w_cows_nxt;
                    r_invalid    <= w_invalid_nxt;
                    if (r_index != LAST_IDX) begin
                        r_index <= r_index + IDX_W'(1);
                    end
                end
                default: begin
                    r_index <= {IDX_W{1'b0}};
                end
            endcase
        end
    end

    // Registered handshake and result outputs; results only move on REPORT
    // entry and otherwise hold across later starts.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
            r_bulls <= {CNT_W{1'b0}};
            r_cows  <= {CNT_W{1'b0}};
            r_win   <= 1'b0;
        end else begin
            r_done <= (r_state == S_REPORT);
            case (r_state)
                S_IDLE: begin
                    r_busy <= bus.start;
                end
                S_COMPARE: begin
                    if (r_index == LAST_IDX) begin
                        r_busy <= 1'b0;
                        if (w_invalid_nxt) begin
                            r_valid <= 1'b0;
                            r_bulls <= {CNT_W{1'b0}};
                            r_cows  <= {CNT_W{1'b0}};
                            r_win   <= 1'b0;
                        end else begin
                            r_valid <= 1'b1;
                            r_bulls <= w_bulls_nxt;
                            r_cows  <= w_cows_nxt;
                            r_win   <= (w_bulls_nxt == ALL_HIT);
                        end
                    end else begin
                        r_busy <= 1'b1;
                    end
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.valid_guess = r_valid;
    assign bus.bulls       = r_bulls;
    assign bus.cows        = r_cows;
    assign bus.win         = r_win;
endmodule

// File: tb/tb_bulls_cows_scorer.sv
// Directed, table-driven bench for bulls_cows_scorer with hand-computed scores
// plus sequences for ignored restarts and reset during scoring.
module tb_bulls_cows_scorer;
    logic clock = 1'b0;
    logic reset = 1'b1;

    int n_vec = 0;
    int n_err = 0;

    int pv_valid = 0;
    int pv_bulls = 0;
    int pv_cows  = 0;
    int pv_win   = 0;

    always #5 clock = ~clock;

    bulls_cows_scorer_if #(.NUM_DIGITS(4), .CNT_W(3)) bus ();

    bulls_cows_scorer #(.NUM_DIGITS(4), .CNT_W(3)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [15:0] secret;
        logic [15:0] guess;
        int          valid;
        int          bulls;
        int          cows;
        int          win;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic launch(input logic [15:0] s, input logic [15:0] g);
        @(negedge clock);
        bus.secret = s;
        bus.guess  = g;
        bus.start  = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
    endtask

    // Observe 12 cycles after the accepting edge; optionally re-pulse start.
    task automatic watch(input int restart_k, input logic [15:0] g2,
                         output int lat, output int bcnt, output int ndone);
        lat = -1;
        bcnt = 0;
        ndone = 0;
        for (int k = 0; k <= 12; k++) begin
            if (k > 0) begin
                @(posedge clock);
                #1;
                bus.start = 1'b0;
            end
            if (bus.busy) bcnt++;
            if (bus.done) begin
                ndone++;
                if (lat < 0) lat = k;
            end
            if (k == restart_k) begin
                bus.guess = g2;
                bus.start = 1'b1;
            end
        end
    endtask

    task automatic check_results(input string tag, input vec_t v);
        chk({tag, ".valid"}, int'(bus.valid_guess), v.valid);
        chk({tag, ".bulls"}, int'(bus.bulls), v.bulls);
        chk({tag, ".cows"},  int'(bus.cows), v.cows);
        chk({tag, ".win"},   int'(bus.win), v.win);
        pv_valid = v.valid;
        pv_bulls = v.bulls;
        pv_cows  = v.cows;
        pv_win   = v.win;
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int lat, bcnt, nd;
        launch(v.secret, v.guess);
        chk({tag, ".hold_bulls"}, int'(bus.bulls), pv_bulls);
        chk({tag, ".hold_valid"}, int'(bus.valid_guess), pv_valid);
        watch(-1, 16'h0000, lat, bcnt, nd);
        chk({tag, ".latency"}, lat, 5);
        chk({tag, ".busy_cycles"}, bcnt, 4);
        chk({tag, ".done_pulses"}, nd, 1);
        check_results(tag, v);
    endtask

    initial begin
        int lat, bcnt, nd;
        vec_t v;

        vt[0] = '{16'h1234, 16'h1234, 1, 4, 0, 1};
        vt[1] = '{16'h1234, 16'h4321, 1, 0, 4, 0};
        vt[2] = '{16'h1234, 16'h1243, 1, 2, 2, 0};
        vt[3] = '{16'h1234, 16'h5678, 1, 0, 0, 0};
        vt[4] = '{16'h1234, 16'h1134, 0, 0, 0, 0};
        vt[5] = '{16'h1234, 16'h12A4, 0, 0, 0, 0};
        vt[6] = '{16'h1234, 16'h1290, 1, 2, 0, 0};
        vt[7] = '{16'h1123, 16'h1234, 1, 1, 2, 0};
        vt[8] = '{16'h9876, 16'hF876, 0, 0, 0, 0};
        vt[9] = '{16'h9876, 16'h9876, 1, 4, 0, 1};

        bus.start  = 1'b0;
        bus.secret = 16'h0000;
        bus.guess  = 16'h0000;
        reset      = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("rst.busy",  int'(bus.busy), 0);
        chk("rst.done",  int'(bus.done), 0);
        chk("rst.valid", int'(bus.valid_guess), 0);
        chk("rst.bulls", int'(bus.bulls), 0);
        chk("rst.cows",  int'(bus.cows), 0);
        chk("rst.win",   int'(bus.win), 0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_vec($sformatf("vec%0d", i), vt[i]);
        end

        // Second start two cycles into scoring must be ignored.
        launch(16'h1234, 16'h1234);
        watch(1, 16'h5678, lat, bcnt, nd);
        chk("restart.latency", lat, 5);
        chk("restart.done_pulses", nd, 1);
        chk("restart.busy_cycles", bcnt, 4);
        v = '{16'h1234, 16'h1234, 1, 4, 0, 1};
        check_results("restart", v);
        run_vec("after_restart", vt[2]);

        // Reset while scoring digit index 2 aborts without a done pulse.
        run_vec("pre_reset", vt[0]);
        launch(16'h1234, 16'h4321);
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        chk("midrst.busy",  int'(bus.busy), 0);
        chk("midrst.done",  int'(bus.done), 0);
        chk("midrst.valid", int'(bus.valid_guess), 0);
        chk("midrst.bulls", int'(bus.bulls), 0);
        chk("midrst.cows",  int'(bus.cows), 0);
        chk("midrst.win",   int'(bus.win), 0);
        nd = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clock);
            #1;
            if (bus.done || bus.busy) nd++;
        end
        chk("midrst.no_activity", nd, 0);
        pv_valid = 0;
        pv_bulls = 0;
        pv_cows  = 0;
        pv_win   = 0;
        run_vec("post_reset", vt[1]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
